// File: rtl/pattern_fetcher.sv
// In-order stream fetcher: issues tagged word reads over a contiguous region,
// absorbs out-of-order tagged responses and emits words in address order.
module pattern_fetcher #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int TAG_COUNT  = 4,
  parameter int TAG_WIDTH  = $clog2(TAG_COUNT),
  parameter int WORD_BYTES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  word_count,
  output logic                  req,
  output logic [TAG_WIDTH-1:0]  req_tag,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_stall,
  input  logic                  push,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int SHIFT = $clog2(WORD_BYTES);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_PENDING, SLOT_FULL} slot_t;

  state_t                state;
  slot_t                 slot_st   [TAG_COUNT];
  logic [DATA_WIDTH-1:0] slot_data [TAG_COUNT];
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  total;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [LEN_WIDTH-1:0]  pop_cnt;
  logic [TAG_WIDTH-1:0]  head;
  logic [TAG_WIDTH-1:0]  next_tag;
  logic                  issue;
  logic                  pop;
  logic                  push_ok;

  // Tags are handed out in order, so the slot at head is always the oldest word.
  assign issue    = (state == RUN) && (issue_cnt < total) &&
                    (slot_st[next_tag] == SLOT_FREE) && !req_stall;
  assign req      = issue;
  assign req_tag  = issue ? next_tag : '0;
  assign req_addr = issue ? base_addr + (ADDR_WIDTH'(issue_cnt) << SHIFT) : '0;

  // Output stream: a word transfers on a cycle where out_valid and out_ready
  // are both high; out_valid never drops and out_data never changes until then.
  assign out_valid = (slot_st[head] == SLOT_FULL);
  assign out_data  = slot_data[head];
  assign pop       = out_valid && out_ready;
  assign push_ok   = push && (slot_st[push_tag] == SLOT_PENDING);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      total     <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      head      <= '0;
      next_tag  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < TAG_COUNT; i++) begin
        slot_st[i]   <= SLOT_FREE;
        slot_data[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (push && !push_ok) err <= 1'b1;
      // Issue, push and pop each require a distinct slot state, so they never collide.
      if (push_ok) begin
        slot_data[push_tag] <= push_data;
        slot_st[push_tag]   <= SLOT_FULL;
      end
      if (issue) begin
        slot_st[next_tag] <= SLOT_PENDING;
        next_tag          <= next_tag + 1'b1;
        issue_cnt         <= issue_cnt + 1'b1;
      end
      if (pop) begin
        slot_st[head] <= SLOT_FREE;
        head          <= head + 1'b1;
        pop_cnt       <= pop_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            base_addr <= start_addr;
            total     <= word_count;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            head      <= '0;
            next_tag  <= '0;
            if (word_count == '0) done  <= 1'b1;
            else                  state <= RUN;
          end
        end
        RUN: begin
          if (pop && (pop_cnt + 1'b1 == total)) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_fetcher.sv
// Directed bench for pattern_fetcher: address order, reordering, stalls,
// zero-length, error flag, address wrap and mid-run reset.
module tb_pattern_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] start_addr;
  logic [31:0] word_count;
  logic        req;
  logic [1:0]  req_tag;
  logic [47:0] req_addr;
  logic        req_stall;
  logic        push;
  logic [1:0]  push_tag;
  logic [63:0] push_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;

  always #5 clk = ~clk;

  pattern_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .word_count(word_count), .req(req), .req_tag(req_tag), .req_addr(req_addr),
    .req_stall(req_stall), .push(push), .push_tag(push_tag), .push_data(push_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  function automatic logic [63:0] data_of(input logic [47:0] a);
    return {16'hA5C3, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_fetch(input logic [47:0] a, input logic [31:0] n);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    push       = 1'b0;
    req_stall  = 1'b0;
    #1;
  endtask

  // Runs a fetch to completion with an in-order responder answering one cycle after each request.
  task automatic flow(input logic [47:0] base, input int count, input int issued0,
                      input int popped0, input int stall_from, input int stall_len,
                      input bit toggle_ready, input int budget);
    int          issued;
    int          popped;
    int          c;
    logic [1:0]  tq[$];
    logic [63:0] dq[$];
    logic [47:0] a;
    issued = issued0;
    popped = popped0;
    c      = 0;
    while (popped < count && c < budget) begin
      @(negedge clk);
      start     = 1'b0;
      req_stall = (c >= stall_from) && (c < stall_from + stall_len);
      out_ready = toggle_ready ? c[0] : 1'b1;
      if (tq.size() > 0) begin
        push      = 1'b1;
        push_tag  = tq.pop_front();
        push_data = dq.pop_front();
      end else begin
        push = 1'b0;
      end
      #1;
      if (req_stall) check("req_under_stall", {63'd0, req}, 64'd0);
      if (req) begin
        a = base + 48'(issued) * 48'd8;
        check("req_addr", {16'd0, req_addr}, {16'd0, a});
        check("req_tag", {62'd0, req_tag}, 64'(issued[1:0]));
        tq.push_back(issued[1:0]);
        dq.push_back(data_of(a));
        issued++;
      end
      if (out_valid) begin
        check("out_data", out_data, data_of(base + 48'(popped) * 48'd8));
        if (out_ready) popped++;
      end
      c++;
    end
    check("flow_words", 64'(popped), 64'(count));
    check("flow_issued", 64'(issued), 64'(count));
    @(negedge clk);
    push      = 1'b0;
    req_stall = 1'b0;
    #1;
    check("done_pulse", {63'd0, done}, 64'd1);
    check("busy_after", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #1;
    check("done_clear", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int         n;
    logic [1:0] ord [4];
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    req_stall  = 1'b0;
    push       = 1'b0;
    push_tag   = '0;
    push_data  = '0;
    out_ready  = 1'b0;
    ord[0] = 2'd3; ord[1] = 2'd1; ord[2] = 2'd2; ord[3] = 2'd0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", {63'd0, req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: three words, in-order responses
    start_fetch(48'h1000, 32'd3);
    check("t1_busy_pre", {63'd0, busy}, 64'd0);
    flow(48'h1000, 3, 0, 0, 0, 0, 1'b0, 30);

    // 2: request window fills at four, then out-of-order responses
    start_fetch(48'h2000, 32'd8);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      #1;
      if (req) begin
        check("t2_req_addr", {16'd0, req_addr}, 64'h2000 + 64'(n) * 64'd8);
        check("t2_req_tag", {62'd0, req_tag}, 64'(n));
        n++;
      end
    end
    check("t2_req_cap", 64'(n), 64'd4);
    check("t2_req_low", {63'd0, req}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      push      = 1'b1;
      push_tag  = ord[i];
      push_data = data_of(48'h2000 + 48'(ord[i]) * 48'd8);
      #1;
      check("t2_no_valid", {63'd0, out_valid}, 64'd0);
      check("t2_no_req", {63'd0, req}, 64'd0);
    end
    @(negedge clk);
    push      = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t2_head_latency", {63'd0, out_valid}, 64'd1);
    check("t2_head_data", out_data, 64'hA5C3_0000_0000_2000);
    flow(48'h2000, 8, 4, 0, 0, 0, 1'b0, 60);

    // 3: zero-length fetch
    start_fetch(48'h1234, 32'd0);
    check("t3_req", {63'd0, req}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_busy", {63'd0, busy}, 64'd0);
    check("t3_req_after", {63'd0, req}, 64'd0);
    @(negedge clk);
    #1;
    check("t3_done_clear", {63'd0, done}, 64'd0);

    // 4: five-cycle request stall with a toggling consumer
    start_fetch(48'h8000, 32'd10);
    flow(48'h8000, 10, 0, 0, 3, 5, 1'b1, 200);

    // 5: push to a free tag while idle, ignored restart, address wrap
    @(negedge clk);
    push      = 1'b1;
    push_tag  = 2'd2;
    push_data = 64'hDEAD;
    #1;
    @(negedge clk);
    push = 1'b0;
    #1;
    check("t5_err", {63'd0, err}, 64'd1);
    check("t5_no_valid", {63'd0, out_valid}, 64'd0);
    start_fetch(48'hFFFF_FFFF_FFF8, 32'd2);
    @(negedge clk);
    start      = 1'b1;
    start_addr = 48'h5000;
    word_count = 32'd7;
    req_stall  = 1'b1;
    #1;
    check("t5_busy", {63'd0, busy}, 64'd1);
    check("t5_stalled", {63'd0, req}, 64'd0);
    flow(48'hFFFF_FFFF_FFF8, 2, 0, 0, 0, 0, 1'b0, 30);
    check("t5_err_sticky", {63'd0, err}, 64'd1);

    // 6: reset with two reads outstanding, then a clean fetch
    start_fetch(48'h3000, 32'd6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_req", {63'd0, req}, 64'd0);
    check("t6_req_addr", {16'd0, req_addr}, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    check("t6_err", {63'd0, err}, 64'd0);
    check("t6_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_out_data", out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    start_fetch(48'h4000, 32'd5);
    flow(48'h4000, 5, 0, 0, 1, 2, 1'b1, 100);
    check("t6_err_clean", {63'd0, err}, 64'd0);
    @(negedge clk);
    push      = 1'b1;
    push_tag  = 2'd1;
    push_data = 64'h5A5A;
    #1;
    @(negedge clk);
    push = 1'b0;
    #1;
    check("t6_stale_err", {63'd0, err}, 64'd1);
    check("t6_stale_valid", {63'd0, out_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
